// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte stream, held-frame and error signals between uart_rx/host (master)
// and the frame controller (slave).
interface uart_rx_frame_ctrl_if #(
  parameter int MAX_LEN = 16
);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          frm_valid;
  logic [7:0]    frm_cmd;
  logic [7:0]    frm_len;
  logic [AW-1:0] pl_raddr;
  logic [7:0]    pl_rdata;
  logic          frm_ack;
  logic          err_len;
  logic          err_chk;
  logic          err_tmo;
  logic          err_ovr;

  modport master (
    output rx_data, rx_valid, pl_raddr, frm_ack,
    input  frm_valid, frm_cmd, frm_len, pl_rdata,
           err_len, err_chk, err_tmo, err_ovr
  );

  modport slave (
    input  rx_data, rx_valid, pl_raddr, frm_ack,
    output frm_valid, frm_cmd, frm_len, pl_rdata,
           err_len, err_chk, err_tmo, err_ovr
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Packet parser behind uart_rx: SOF,CMD,LEN,PAYLOAD[LEN],CHK with length,
// checksum and inter-byte timeout checks; holds a good frame until acked.
//
// state  | meaning
// S_IDLE | hunting for SOF, other bytes dropped silently
// S_CMD  | next byte is CMD
// S_LEN  | next byte is LEN
// S_PAY  | collecting LEN payload bytes
// S_CHK  | next byte is the checksum
// S_HOLD | good frame presented, waiting for frm_ack
module uart_rx_frame_ctrl #(
  parameter int         CLOCK_FREQ    = 50_000_000,
  parameter int         BAUD_RATE     = 115_200,
  parameter logic [7:0] SOF           = 8'hA5,
  parameter int         MAX_LEN       = 16,
  parameter int         TIMEOUT_BYTES = 4
) (
  input logic            clk,
  input logic            n_rst,
  uart_rx_frame_ctrl_if.slave bus
);

  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 2 ** AW;
  localparam int TMO   = TIMEOUT_BYTES * 10 * (CLOCK_FREQ / BAUD_RATE);
  localparam int CW    = $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TMO - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN, S_PAY, S_CHK, S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    idx_q, idx_d;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    frm_cmd_q, frm_cmd_d;
  logic [7:0]    frm_len_q, frm_len_d;
  logic          err_len_q, err_len_d;
  logic          err_chk_q, err_chk_d;
  logic          err_tmo_q, err_tmo_d;
  logic          err_ovr_q, err_ovr_d;
  logic [7:0]    pl_buf_q [DEPTH];
  logic [7:0]    pl_buf_d [DEPTH];

  logic timer_run;
  logic tmo_hit;

  assign timer_run = (state_q == S_CMD) || (state_q == S_LEN) ||
                     (state_q == S_PAY) || (state_q == S_CHK);
  // A strobe in the terminal cycle takes precedence over the timeout.
  assign tmo_hit   = timer_run && !bus.rx_valid && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    len_d     = len_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    frm_cmd_d = frm_cmd_q;
    frm_len_d = frm_len_q;
    pl_buf_d  = pl_buf_q;
    err_len_d = 1'b0;
    err_chk_d = 1'b0;
    err_tmo_d = 1'b0;
    err_ovr_d = 1'b0;
    tmo_cnt_d = '0;

    if (timer_run && !bus.rx_valid && (tmo_cnt_q != TMO_LAST))
      tmo_cnt_d = tmo_cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid && (bus.rx_data == SOF))
          state_d = S_CMD;
      end
      S_CMD: begin
        if (bus.rx_valid) begin
          cmd_d   = bus.rx_data;
          sum_d   = bus.rx_data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (bus.rx_valid) begin
          len_d = bus.rx_data;
          sum_d = sum_q + bus.rx_data;
          idx_d = '0;
          if (bus.rx_data > MAX_LEN_B) begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end else if (bus.rx_data == 8'h00) begin
            state_d = S_CHK;
          end else begin
            state_d = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (bus.rx_valid) begin
          pl_buf_d[idx_q[AW-1:0]] = bus.rx_data;
          sum_d = sum_q + bus.rx_data;
          idx_d = idx_q + 8'd1;
          if ((idx_q + 8'd1) == len_q)
            state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == sum_q) begin
            frm_cmd_d = cmd_q;
            frm_len_d = len_q;
            state_d   = S_HOLD;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        // Bytes arriving while a frame is held are dropped, ack cycle included.
        if (bus.rx_valid)
          err_ovr_d = 1'b1;
        if (bus.frm_ack)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (tmo_hit) begin
      err_tmo_d = 1'b1;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      tmo_cnt_q <= '0;
      frm_cmd_q <= '0;
      frm_len_q <= '0;
      err_len_q <= 1'b0;
      err_chk_q <= 1'b0;
      err_tmo_q <= 1'b0;
      err_ovr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        pl_buf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      tmo_cnt_q <= tmo_cnt_d;
      frm_cmd_q <= frm_cmd_d;
      frm_len_q <= frm_len_d;
      err_len_q <= err_len_d;
      err_chk_q <= err_chk_d;
      err_tmo_q <= err_tmo_d;
      err_ovr_q <= err_ovr_d;
      pl_buf_q  <= pl_buf_d;
    end
  end

  assign bus.frm_valid = (state_q == S_HOLD);
  assign bus.frm_cmd   = frm_cmd_q;
  assign bus.frm_len   = frm_len_q;
  assign bus.pl_rdata  = pl_buf_q[bus.pl_raddr];
  assign bus.err_len   = err_len_q;
  assign bus.err_chk   = err_chk_q;
  assign bus.err_tmo   = err_tmo_q;
  assign bus.err_ovr   = err_ovr_q;

endmodule
